mem_ctrl_ram: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request interface, per-lane write enables, a registered response stage with back-pressure, and a hardware clear sequencer after reset. It is the next-generation data/instruction store for the microprocessor datapath. It replaces the shared tri-state data bus with separate write and read paths, and replaces the per-address reset with a deterministic full-array sweep.

---
 rtl/mem_ctrl_ram.sv | 121 ++++++++++++
 tb/tb_mem_ctrl_ram.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous RAM with a valid/ready request port, per-lane write enables,
// a back-pressured response register and a post-reset zeroing sweep.
module mem_ctrl_ram #(
    parameter int ADDR_SIZE      = 4,
    parameter int DEPTH          = 2**ADDR_SIZE,
    parameter int WIDTH          = 8,
    parameter int LANE_W         = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LANES         = WIDTH / LANE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    input  logic [LANES-1:0]     req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_we,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam state_t                 RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic [ADDR_SIZE:0]     DEPTH_W     = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE-1:0]   LAST_WORD   = ADDR_SIZE'(DEPTH - 1);

    state_t                 state_reg, state_next;
    logic [ADDR_SIZE-1:0]   sweep_cnt_reg, sweep_cnt_next;
    logic                   rsp_valid_reg, rsp_we_reg, rsp_err_reg;
    logic [WIDTH-1:0]       rsp_rdata_reg;

    logic                   accept;
    logic                   in_range;
    logic                   wr_en;
    logic [ADDR_SIZE-1:0]   wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [LANES-1:0]       wr_be;
    logic [WIDTH-1:0]       rd_word;

    assign req_ready = (state_reg == READY) && (!rsp_valid_reg || rsp_ready);
    assign busy      = (state_reg == CLEAR);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);

    assign rsp_valid = rsp_valid_reg;
    assign rsp_we    = rsp_we_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

    // The single write port is shared: the sweep owns it in CLEAR, requests in READY.
    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        wr_en          = 1'b0;
        wr_addr        = req_addr;
        wr_data        = req_wdata;
        wr_be          = req_be;
        case (state_reg)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = sweep_cnt_reg;
                wr_data = '0;
                wr_be   = '1;
                if (sweep_cnt_reg == LAST_WORD) begin
                    state_next     = READY;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + ADDR_SIZE'(1);
                end
            end
            READY: begin
                wr_en = accept && req_we && in_range;
            end
            default: state_next = RESET_STATE;
        endcase
    end

    // One narrow array per lane so each byte column maps onto its own RAM slice.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_addr] <= wr_data[gi*LANE_W +: LANE_W];
                end
            end

            assign rd_word[gi*LANE_W +: LANE_W] = lane_mem[req_addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_STATE;
            sweep_cnt_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
            if (accept) begin
                rsp_valid_reg <= 1'b1;
                rsp_we_reg    <= req_we;
                rsp_err_reg   <= !in_range;
                rsp_rdata_reg <= (!req_we && in_range) ? rd_word : '0;
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// Randomised and directed scoreboard bench for mem_ctrl_ram (16-bit words, 2 lanes, 12 words).
module tb_mem_ctrl_ram;

    localparam int AW = 4;
    localparam int D  = 12;
    localparam int W  = 16;
    localparam int LW = 8;
    localparam int LN = W / LW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [LN-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_we;
    logic          rsp_err;
    logic          busy;

    typedef struct packed {
        logic         we;
        logic         err;
        logic [W-1:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    logic [W-1:0] model [16];
    int          checks   = 0;
    int          failures = 0;

    mem_ctrl_ram #(
        .ADDR_SIZE(AW), .DEPTH(D), .WIDTH(W), .LANE_W(LW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // Reference behaviour for the request currently on the bus, applied at acceptance.
    task automatic accept_req();
        rsp_t e;
        if (int'(req_addr) >= D) begin
            e = '{we: req_we, err: 1'b1, rdata: '0};
        end else if (req_we) begin
            for (int l = 0; l < LN; l++)
                if (req_be[l]) model[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
            e = '{we: 1'b1, err: 1'b0, rdata: '0};
        end else begin
            e = '{we: 1'b0, err: 1'b0, rdata: model[req_addr]};
        end
        sb.push_back(e);
        $display("REQ we=%0d addr=%0d wdata=%h be=%b -> exp we=%0d err=%0d rdata=%h",
                 req_we, req_addr, req_wdata, req_be, e.we, e.err, e.rdata);
    endtask

    // Monitor: pops one expectation per retired response; also checks hold stability.
    logic        hold_prev = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (hold_prev) check("rsp_hold_stable", 32'({rsp_we, rsp_err, rsp_rdata}), 32'(held));
            if (rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'({rsp_we, rsp_err, rsp_rdata}), 32'h3ffff);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", 32'({rsp_we, rsp_err, rsp_rdata}), 32'(e));
                end
            end
            hold_prev = !rsp_ready;
            held      = {rsp_we, rsp_err, rsp_rdata};
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Caller sits just after a rising edge; returns how many cycles the request waited.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [LN-1:0] be, output int waits);
        waits     = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            if (req_ready) begin
                accept_req();
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waits++;
            if (waits > 50) begin
                check("issue_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Called at the negedge where rst_n was just released; counts edges until busy drops.
    task automatic wait_sweep();
        int   n   = 0;
        logic bad = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
            if (req_ready) bad = 1'b1;
            if (n >= 100) break;
        end
        req_valid = 1'b0;
        check("sweep_len", 32'(n), 32'(D));
        check("ready_during_clear", 32'(bad), 32'd0);
        check("ready_after_sweep", 32'(req_ready), 32'd1);
    endtask

    task automatic read_all();
        int w;
        for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, '0, w);
        drain();
    endtask

    initial begin
        int w;
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [W-1:0] exp_hold;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        clear_model();

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_we_err", 32'({rsp_we, rsp_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sweep();
        read_all();

        // Write then read back-to-back on the same address.
        issue(1'b1, 4'd3, 16'h00A5, 2'b01, w);
        issue(1'b0, 4'd3, '0, '0, w);
        check("raw_back_to_back_waits", 32'(w), 32'd0);
        drain();

        // Partial-lane update.
        issue(1'b1, 4'd5, 16'h1234, 2'b11, w);
        issue(1'b1, 4'd5, 16'hFFFF, 2'b01, w);
        issue(1'b0, 4'd5, '0, '0, w);
        drain();

        // Out-of-range accesses leave the array untouched.
        issue(1'b0, 4'd13, '0, '0, w);
        issue(1'b1, 4'd13, 16'h0077, 2'b11, w);
        issue(1'b0, 4'd13, '0, '0, w);
        issue(1'b0, 4'd12, '0, '0, w);
        drain();
        read_all();

        // Back-pressure: hold a read response for three cycles, then retire+accept together.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; req_wdata = '0; req_be = '0;
        @(negedge clk);
        check("bp_first_ready", 32'(req_ready), 32'd1);
        if (req_ready) accept_req();
        exp_hold = 16'h12FF;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 4'd6; req_wdata = 16'hBEEF; req_be = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            check("bp_held_rsp", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, exp_hold}));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        if (req_ready) accept_req();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_new_rsp", 32'({rsp_valid, rsp_we}), 32'b11);
        drain();
        issue(1'b0, 4'd6, '0, '0, w);
        drain();

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = W'($urandom);
            req_be    = LN'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_valid && req_ready) accept_req();
            @(posedge clk); #1;
        end
        drain();
        read_all();

        // Reset with a response pending, then again in the middle of the sweep.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        @(negedge clk);
        if (req_ready) accept_req();
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midtx_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midtx_rst_rdata", 32'(rsp_rdata), 32'd0);
        check("midtx_rst_busy_ready", 32'({busy, req_ready}), 32'b10);
        sb.delete();
        clear_model();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 16'h5555; req_be = 2'b11;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_busy_ready", 32'({busy, req_ready, rsp_valid}), 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep();
        read_all();

        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
